// File: rtl/rr_arb_pkg.sv
// Shared constants for the round-robin arbiter.
//   RR_NUM_REQ_DEF : default requester count
//   idx_w(n)       : width of an index into n requesters (at least 1 bit)
package rr_arb_pkg;
  localparam int RR_NUM_REQ_DEF = 4;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
//   req   : one bit per requester, driven by the masters
//   grant : registered one-hot (or zero) grant, driven by the arbiter
// modport master : requester side (drives req, sees grant)
// modport slave  : arbiter side (sees req, drives grant)
interface rr_arbiter_if
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ = RR_NUM_REQ_DEF
) ();
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;

  modport master (output req, input  grant);
  modport slave  (input  req, output grant);
endinterface

// File: rtl/rr_arbiter_rotate_pick.sv
// Rotated priority encoder: returns the first set bit of req at or after
// start, wrapping from NUM_REQ-1 to 0.
//   req   : candidate vector
//   start : index searched first
//   found : any bit of req set
//   idx   : winning index (valid when found)
// The low half of a double-width vector holds req masked to indices >= start,
// the high half holds the full req; the lowest set bit of that vector is the
// first hit in cyclic order starting from start.
module rr_rotate_pick
  import rr_arb_pkg::*;
#(
  parameter  int NUM_REQ = RR_NUM_REQ_DEF,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      start,
  output logic               found,
  output logic [IW-1:0]      idx
);
  logic [NUM_REQ-1:0]   mask;
  logic [2*NUM_REQ-1:0] dbl;
  logic [IW:0]          pos;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_REQ; i++)
      mask[i] = (i >= int'(start));
    dbl   = {req, req & mask};
    found = |req;
    pos   = '0;
    // descending scan so the lowest set bit wins
    for (int i = 2*NUM_REQ-1; i >= 0; i--)
      if (dbl[i]) pos = (IW+1)'(i);
    if (int'(pos) >= NUM_REQ) idx = IW'(int'(pos) - NUM_REQ);
    else                      idx = IW'(int'(pos));
  end
endmodule

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter with one-hot grant.
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset
//   bus.req  : request vector (input)
//   bus.grant: registered grant, one-hot or zero (output)
// The grantee keeps the grant while it holds its request; on release the
// grant moves on the same edge to the next requester after the last grantee.
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int NUM_REQ = RR_NUM_REQ_DEF,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter_if.slave   bus
);
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      start;
  logic               hold;
  logic               found;
  logic [IW-1:0]      pick_idx;

  rr_rotate_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (bus.req),
    .start (start),
    .found (found),
    .idx   (pick_idx)
  );

  always_comb begin
    // grant_q is one-hot or zero, so any overlap means the grantee still asks
    hold    = |(grant_q & bus.req);
    start   = (last_q == IW'(NUM_REQ-1)) ? '0 : last_q + IW'(1);
    grant_d = grant_q;
    last_d  = last_q;
    if (!hold) begin
      grant_d = '0;
      if (found) begin
        grant_d[pick_idx] = 1'b1;
        last_d            = pick_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_q <= '0;
      last_q  <= IW'(NUM_REQ-1);
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign bus.grant = grant_q;
endmodule

// File: tb/tb_rr_arbiter.sv
module tb_rr_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rnd_phase = 1'b0;

  logic [N-1:0] exp_q [$];

  // reference model state: current grantee (-1 = none) and last grantee
  int m_gnt;
  int m_last;

  rr_arbiter_if #(.NUM_REQ(N)) bus ();
  rr_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // directed table: {rst, req[3:0], expected grant[3:0]}
  localparam int NDIR = 26;
  logic [8:0] dir_tbl [NDIR] = '{
    9'b0_1111_0000, 9'b0_1111_0000, 9'b1_0000_0000,
    9'b1_1111_0001, 9'b1_1111_0001, 9'b1_1111_0001, 9'b1_1111_0001,
    9'b1_1110_0010, 9'b1_1101_0100, 9'b1_1100_0100, 9'b1_1011_1000,
    9'b1_1010_1000, 9'b1_1001_1000, 9'b1_1000_1000, 9'b1_1111_1000,
    9'b1_0111_0001, 9'b1_0110_0010,
    9'b1_0000_0000, 9'b1_1111_0100,
    9'b0_1111_0000, 9'b1_1111_0001,
    9'b1_0000_0000, 9'b1_0001_0001,
    9'b1_0001_0001, 9'b1_0000_0000, 9'b1_0010_0010
  };

  function automatic logic [N-1:0] model_step(input logic r, input logic [N-1:0] rq);
    logic [N-1:0] g;
    if (!r) begin
      m_gnt  = -1;
      m_last = N-1;
    end else if (!(m_gnt >= 0 && rq[m_gnt])) begin
      m_gnt = -1;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (rq[c] && m_gnt < 0) m_gnt = c;
      end
      if (m_gnt >= 0) m_last = m_gnt;
    end
    g = '0;
    if (m_gnt >= 0) g[m_gnt] = 1'b1;
    return g;
  endfunction

  // drive one cycle's inputs away from the active edge and queue the
  // grant expected after the coming edge
  task automatic step(input logic r, input logic [N-1:0] rq, input bit use_model,
                      input logic [N-1:0] want);
    logic [N-1:0] m;
    @(negedge clk);
    rst     = r;
    bus.req = rq;
    m = model_step(r, rq);
    exp_q.push_back(use_model ? m : want);
  endtask

  // monitor: every edge that has a queued expectation
  logic [N-1:0] prev_g = '0;
  int           wait_cnt [N];
  initial foreach (wait_cnt[i]) wait_cnt[i] = 0;

  always @(posedge clk) begin
    logic [N-1:0] e, g, rq;
    bit           evt;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      g  = bus.grant;
      rq = bus.req;
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL grant t=%0t: got %b want %b (req %b rst %b)", $time, g, e, rq, rst);
      end
      n_cmp++;
      if (!$onehot0(g)) begin
        n_bad++;
        $display("FAIL onehot t=%0t: got %b want one-hot or zero", $time, g);
      end
      if (rnd_phase) begin
        evt = (g != '0) && (g != prev_g);
        for (int i = 0; i < N; i++) begin
          if (g[i] && evt) begin
            n_cmp++;
            if (wait_cnt[i] > N-1) begin
              n_bad++;
              $display("FAIL starve req%0d: waited %0d grants, want <= %0d", i, wait_cnt[i], N-1);
            end
          end
          if (!rq[i] || g[i]) wait_cnt[i] = 0;
          else if (evt)       wait_cnt[i]++;
        end
      end
      prev_g = g;
    end
  end

  initial begin
    logic [N-1:0] rq;
    rst     = 1'b0;
    bus.req = '1;
    m_gnt   = -1;
    m_last  = N-1;

    for (int i = 0; i < NDIR; i++) begin
      logic [8:0] t;
      t = dir_tbl[i];
      step(t[8], t[7:4], 1'b0, t[3:0]);
    end

    // random phase: bits flip with probability 1/4 so requests persist
    step(1'b0, '0, 1'b1, '0);
    repeat (2) @(negedge clk);
    foreach (wait_cnt[i]) wait_cnt[i] = 0;
    prev_g    = '0;
    rnd_phase = 1'b1;
    rq = '0;
    for (int c = 0; c < 1000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(3) == 0) rq[b] = ~rq[b];
      step(1'b1, rq, 1'b1, '0);
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
